// File: rtl/apb_timer_s_if.sv
// APB bus bundle between the interconnect (master) and the timer responder (slave).
interface apb_timer_s_if #(
  parameter int unsigned BUS_WIDTH = 16
) ();
  logic [BUS_WIDTH-1:0] S_PADDR;
  logic                 S_PWRITE;
  logic                 S_PSELx;
  logic                 S_PENABLE;
  logic [BUS_WIDTH-1:0] S_PWDATA;
  logic [BUS_WIDTH-1:0] S_PRDATA;
  logic                 S_PREADY;

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY
  );

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY
  );
endinterface

// File: rtl/apb_timer_s.sv
// APB responder with a 16-bit down-counting timer, reload, expiry flag and interrupt.
// Every access takes 1 + WAIT_STATES cycles; S_PREADY is a one-cycle registered pulse.
module apb_timer_s #(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  apb_timer_s_if.slave   s_apb,
  output logic           out_irq
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [3:0]           r_wait_cnt;
  logic [2:0]           r_ctrl;
  logic [BUS_WIDTH-1:0] r_load;
  logic [BUS_WIDTH-1:0] r_count;
  logic                 r_expired;
  logic [BUS_WIDTH-1:0] r_prdata;
  logic                 r_pready;

  logic                 w_start;
  logic                 w_capture;
  logic                 w_commit;
  logic                 w_pready_next;
  logic                 w_expire;
  logic                 w_wr_ctrl;
  logic                 w_wr_load;
  logic                 w_wr_count;
  logic                 w_wr_status;
  logic [BUS_WIDTH-1:0] w_rdata;
  logic                 w_unused;

  assign w_start  = s_apb.S_PSELx & s_apb.S_PENABLE;
  assign w_unused = ^s_apb.S_PADDR[BUS_WIDTH-1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; losing PSELx while stalled abandons the transfer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = (WAIT_STATES == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (!s_apb.S_PSELx) begin
          w_state_next = StIdle;
        end else if (r_wait_cnt == 4'd1) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    w_pready_next = (w_state_next == StDone);
    w_capture     = (w_state_next == StDone) && (r_state != StDone);
    w_commit      = (r_state == StDone) && s_apb.S_PWRITE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == StIdle && w_start) begin
      r_wait_cnt <= 4'(WAIT_STATES);
    end else if (r_state == StWait) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_comb begin
    w_wr_ctrl   = w_commit && (s_apb.S_PADDR[1:0] == 2'd0);
    w_wr_load   = w_commit && (s_apb.S_PADDR[1:0] == 2'd1);
    w_wr_count  = w_commit && (s_apb.S_PADDR[1:0] == 2'd2);
    w_wr_status = w_commit && (s_apb.S_PADDR[1:0] == 2'd3);
    w_expire    = r_ctrl[0] && (r_count == '0);
  end

  always_comb begin
    w_rdata = '0;
    case (s_apb.S_PADDR[1:0])
      2'd0:    w_rdata[2:0] = r_ctrl;
      2'd1:    w_rdata      = r_load;
      2'd2:    w_rdata      = r_count;
      default: w_rdata[0]   = r_expired;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prdata <= '0;
      r_pready <= 1'b0;
    end else begin
      r_pready <= w_pready_next;
      if (w_capture) begin
        r_prdata <= w_rdata;
      end
    end
  end

  // Bus writes are assigned after the timer update so they take precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      if (r_ctrl[0]) begin
        if (r_count != '0) begin
          r_count <= r_count - BUS_WIDTH'(1);
        end else if (r_ctrl[1]) begin
          r_count <= r_load;
        end else begin
          r_ctrl[0] <= 1'b0;
        end
      end
      if (w_wr_ctrl) begin
        r_ctrl <= s_apb.S_PWDATA[2:0];
      end
      if (w_wr_load) begin
        r_load <= s_apb.S_PWDATA;
      end
      if (w_wr_count) begin
        r_count <= s_apb.S_PWDATA;
      end
      if (w_wr_status && s_apb.S_PWDATA[0]) begin
        r_expired <= 1'b0;
      end
      if (w_expire) begin
        r_expired <= 1'b1;
      end
    end
  end

  assign s_apb.S_PRDATA = r_prdata;
  assign s_apb.S_PREADY = r_pready;
  assign out_irq        = r_expired & r_ctrl[2];

endmodule

// File: tb/tb_apb_timer_s.sv
// Directed bench for apb_timer_s: one instance with no wait states, one with three.
module tb_apb_timer_s;

  logic        clk;
  logic        reset;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic        psel0;
  logic        psel3;
  logic        cur;
  logic        irq0;
  logic        irq3;
  int          checks;
  int          failures;

  apb_timer_s_if #(.BUS_WIDTH(16)) bus0 ();
  apb_timer_s_if #(.BUS_WIDTH(16)) bus3 ();

  assign bus0.S_PADDR   = paddr;
  assign bus0.S_PWRITE  = pwrite;
  assign bus0.S_PENABLE = penable;
  assign bus0.S_PWDATA  = pwdata;
  assign bus0.S_PSELx   = psel0;
  assign bus3.S_PADDR   = paddr;
  assign bus3.S_PWRITE  = pwrite;
  assign bus3.S_PENABLE = penable;
  assign bus3.S_PWDATA  = pwdata;
  assign bus3.S_PSELx   = psel3;

  apb_timer_s #(.BUS_WIDTH(16), .WAIT_STATES(0)) u_dut0 (
    .clk     (clk),
    .reset   (reset),
    .s_apb   (bus0),
    .out_irq (irq0)
  );

  apb_timer_s #(.BUS_WIDTH(16), .WAIT_STATES(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .s_apb   (bus3),
    .out_irq (irq3)
  );

  logic        rdy;
  logic [15:0] rdat;
  assign rdy  = cur ? bus3.S_PREADY : bus0.S_PREADY;
  assign rdat = cur ? bus3.S_PRDATA : bus0.S_PRDATA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full APB transfer: setup, access, bounded wait for PREADY, then pulse-width check
  task automatic xfer(input logic which, input logic wr, input logic [1:0] a,
                      input logic [15:0] wd, output logic [15:0] rd);
    int lat;
    bit done;
    int exp_lat;
    exp_lat = which ? 4 : 1;
    cur = which;
    @(posedge clk);
    #1;
    paddr   = {14'h0, a};
    pwrite  = wr;
    pwdata  = wd;
    penable = 1'b0;
    if (which) psel3 = 1'b1;
    else       psel0 = 1'b1;
    @(posedge clk);
    #1 penable = 1'b1;
    lat  = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rdy) done = 1;
      else     lat++;
    end
    if (!done) chk("pready_timeout", int'(rdy), 1);
    chk("latency", lat, exp_lat);
    rd = rdat;
    @(posedge clk);
    #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("pready_width", int'(rdy), 0);
  endtask

  task automatic wr_reg(input logic which, input logic [1:0] a, input logic [15:0] d);
    logic [15:0] dummy;
    xfer(which, 1'b1, a, d, dummy);
  endtask

  task automatic rd_reg(input logic which, input logic [1:0] a, input logic [15:0] exp,
                        input string tag);
    logic [15:0] d;
    xfer(which, 1'b0, a, 16'h0, d);
    chk(tag, int'(d), int'(exp));
  endtask

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    paddr    = '0;
    pwdata   = '0;
    pwrite   = 1'b0;
    penable  = 1'b0;
    psel0    = 1'b0;
    psel3    = 1'b0;
    cur      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pready0", int'(bus0.S_PREADY), 0);
    chk("rst_pready3", int'(bus3.S_PREADY), 0);
    chk("rst_irq0", int'(irq0), 0);
    chk("rst_prdata0", int'(bus0.S_PRDATA), 0);

    rd_reg(1'b0, 2'd0, 16'h0000, "rst_ctrl");
    rd_reg(1'b0, 2'd1, 16'h0000, "rst_load");
    rd_reg(1'b0, 2'd2, 16'h0000, "rst_count");
    rd_reg(1'b0, 2'd3, 16'h0000, "rst_status");

    wr_reg(1'b1, 2'd1, 16'h1234);
    rd_reg(1'b1, 2'd1, 16'h1234, "ws3_load_rb");

    // One-shot: count 5 down to 0, expire on the sixth enabled cycle
    wr_reg(1'b0, 2'd2, 16'd5);
    wr_reg(1'b0, 2'd0, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("oneshot_irq_low", int'(irq0), 0);
    end
    @(negedge clk);
    chk("oneshot_irq_high", int'(irq0), 1);
    rd_reg(1'b0, 2'd2, 16'h0000, "oneshot_count");
    rd_reg(1'b0, 2'd0, 16'h0004, "oneshot_ctrl");
    rd_reg(1'b0, 2'd3, 16'h0001, "oneshot_status");
    wr_reg(1'b0, 2'd3, 16'h0001);
    chk("clear_irq", int'(irq0), 0);

    // Auto-reload, period 3: successive reads sample after edges 2, 6, 10
    wr_reg(1'b0, 2'd1, 16'd2);
    wr_reg(1'b0, 2'd2, 16'd2);
    wr_reg(1'b0, 2'd0, 16'h0003);
    rd_reg(1'b0, 2'd2, 16'd0, "reload_count_a");
    rd_reg(1'b0, 2'd2, 16'd2, "reload_count_b");
    rd_reg(1'b0, 2'd2, 16'd1, "reload_count_c");
    rd_reg(1'b0, 2'd3, 16'h0001, "reload_status");
    wr_reg(1'b0, 2'd0, 16'h0000);
    wr_reg(1'b0, 2'd3, 16'h0001);
    rd_reg(1'b0, 2'd3, 16'h0000, "status_cleared");
    chk("reload_irq", int'(irq0), 0);
    rd_reg(1'b0, 2'd2, 16'h0000, "stopped_count");

    // Clear lands on the expiry edge (edge 6 after the CTRL write)
    wr_reg(1'b0, 2'd2, 16'd2);
    wr_reg(1'b0, 2'd0, 16'h0003);
    repeat (2) @(posedge clk);
    wr_reg(1'b0, 2'd3, 16'h0001);
    rd_reg(1'b0, 2'd3, 16'h0001, "set_beats_clear");
    // COUNT write on a decrement edge wins, then two more decrements before sampling
    wr_reg(1'b0, 2'd2, 16'h00FF);
    rd_reg(1'b0, 2'd2, 16'h00FD, "count_write_wins");
    wr_reg(1'b0, 2'd0, 16'h0000);

    // Abort: PSELx dropped while stalled in WAIT
    cur = 1'b1;
    seen = 0;
    @(posedge clk);
    #1;
    paddr   = 16'd1;
    pwrite  = 1'b1;
    pwdata  = 16'hBEEF;
    penable = 1'b0;
    psel3   = 1'b1;
    @(posedge clk);
    #1 penable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus3.S_PREADY) seen = 1;
    end
    @(posedge clk);
    #1;
    psel3   = 1'b0;
    penable = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus3.S_PREADY) seen = 1;
    end
    chk("abort_no_pready", int'(seen), 0);
    rd_reg(1'b1, 2'd1, 16'h1234, "abort_load_kept");

    // Reset while a COUNT write is stalled in WAIT
    @(posedge clk);
    #1;
    paddr   = 16'd2;
    pwrite  = 1'b1;
    pwdata  = 16'h0055;
    psel3   = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("midrst_pready", int'(bus3.S_PREADY), 0);
    chk("midrst_irq", int'(irq3), 0);
    rd_reg(1'b1, 2'd0, 16'h0000, "midrst_ctrl");
    rd_reg(1'b1, 2'd1, 16'h0000, "midrst_load");
    rd_reg(1'b1, 2'd2, 16'h0000, "midrst_count");
    rd_reg(1'b1, 2'd3, 16'h0000, "midrst_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
